// File: rtl/gate_unit_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : gate_unit_arbiter
// Description : Round-robin arbiter that shares one mux-built logic-gate
//               unit (AND/OR/NAND/NOR/XOR/XNOR) among N_REQ requesters and
//               returns each result through one registered, ID-tagged slot.
//               Optional macro GATE_ARB_ERR_EN adds a resp_err output that
//               flags reserved opcodes (6, 7).
// Revision    : 1.0 - initial release
// ============================================================================
module gate_unit_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [N_REQ-1:0]   req_a,
    input  logic [N_REQ-1:0]   req_b,
    input  logic [3*N_REQ-1:0] req_op,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [ID_W-1:0]    resp_id,
    output logic               resp_y
`ifdef GATE_ARB_ERR_EN
    ,
    output logic               resp_err
`endif
);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    localparam logic [ID_W:0]   C_N_REQ   = (ID_W+1)'(N_REQ);
    localparam logic [ID_W-1:0] C_LAST_ID = ID_W'(N_REQ-1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [ID_W-1:0] r_rr_ptr;
    logic            w_can_accept;
    logic            w_found;
    logic            w_accept;
    logic [ID_W-1:0] w_win;
    logic [ID_W:0]   w_scan;
    logic            w_sel_a;
    logic            w_sel_b;
    logic [2:0]      w_sel_op;
    logic            w_in0;
    logic            w_in1;
    logic            w_y;

    // The slot state is exposed directly as resp_valid
    assign resp_valid   = (r_state == ST_FULL);
    assign w_can_accept = !resp_valid || resp_ready;
    assign w_accept     = !rst && w_can_accept && w_found;

    // Scan requests starting at the pointer; wrap uses an explicit compare so
    // non-power-of-two requester counts stay in range
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_scan  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_scan = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
            if (w_scan >= C_N_REQ) begin
                w_scan = w_scan - C_N_REQ;
            end
            if (!w_found && req_valid[w_scan[ID_W-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_scan[ID_W-1:0];
            end
        end
    end

    // One-hot grant to the winner, only when the slot can take a result
    always_comb begin
        req_ready = '0;
        if (w_accept) begin
            req_ready[w_win] = 1'b1;
        end
    end

    // Route the winner's operands and opcode to the shared gate
    always_comb begin
        w_sel_a  = 1'b0;
        w_sel_b  = 1'b0;
        w_sel_op = 3'd0;
        for (int i = 0; i < N_REQ; i++) begin
            if (ID_W'(i) == w_win) begin
                w_sel_a  = req_a[i];
                w_sel_b  = req_b[i];
                w_sel_op = req_op[3*i +: 3];
            end
        end
    end

    // Gate built as a 2:1 mux with a as select; reserved opcodes give 0
    always_comb begin
        w_in0 = 1'b0;
        w_in1 = 1'b0;
        case (w_sel_op)
            3'd0:    begin w_in0 = 1'b0;     w_in1 = w_sel_b;  end
            3'd1:    begin w_in0 = w_sel_b;  w_in1 = 1'b1;     end
            3'd2:    begin w_in0 = 1'b1;     w_in1 = ~w_sel_b; end
            3'd3:    begin w_in0 = ~w_sel_b; w_in1 = 1'b0;     end
            3'd4:    begin w_in0 = w_sel_b;  w_in1 = ~w_sel_b; end
            3'd5:    begin w_in0 = ~w_sel_b; w_in1 = w_sel_b;  end
            default: begin w_in0 = 1'b0;     w_in1 = 1'b0;     end
        endcase
        w_y = w_sel_a ? w_in1 : w_in0;
    end

    // Slot next state: fill on accept, drain when consumed with no refill
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: if (w_accept) w_state_nxt = ST_FULL;
            ST_FULL:  if (resp_ready && !w_accept) w_state_nxt = ST_EMPTY;
            default:  w_state_nxt = ST_EMPTY;
        endcase
    end

    // Slot state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Round-robin pointer advances past the winner on every accept
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (w_accept) begin
            r_rr_ptr <= (w_win == C_LAST_ID) ? '0 : w_win + 1'b1;
        end
    end

    // Response payload loads only on accept, so it holds under backpressure
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_id <= '0;
            resp_y  <= 1'b0;
        end else if (w_accept) begin
            resp_id <= w_win;
            resp_y  <= w_y;
        end
    end

`ifdef GATE_ARB_ERR_EN
    // Reserved-opcode flag travels with the payload
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_err <= 1'b0;
        end else if (w_accept) begin
            resp_err <= (w_sel_op[2:1] == 2'b11);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_gate_unit_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_gate_unit_arbiter
// Description : Self-checking bench for gate_unit_arbiter: directed steps
//               followed by random traffic, compared against a behavioural
//               model of arbitration, slot and gate truth tables.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gate_unit_arbiter;

    localparam int N   = 4;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   req_a;
    logic [N-1:0]   req_b;
    logic [3*N-1:0] req_op;
    logic           resp_valid;
    logic           resp_ready;
    logic [IDW-1:0] resp_id;
    logic           resp_y;
`ifdef GATE_ARB_ERR_EN
    logic           resp_err;
`endif

    gate_unit_arbiter #(.N_REQ(N), .ID_W(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_id   (resp_id),
        .resp_y    (resp_y)
`ifdef GATE_ARB_ERR_EN
        ,
        .resp_err  (resp_err)
`endif
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    // Behavioural model state
    int m_ptr   = 0;
    bit m_valid = 1'b0;
    int m_id    = 0;
    bit m_y     = 1'b0;
    bit m_err   = 1'b0;

    logic [N-1:0] obs_ready;
    logic [N-1:0] order_exp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit gate(input bit a, input bit b, input int op);
        case (op)
            0:       return a & b;
            1:       return a | b;
            2:       return !(a & b);
            3:       return !(a | b);
            4:       return a ^ b;
            5:       return !(a ^ b);
            default: return 1'b0;
        endcase
    endfunction

    // One clock of stimulus: check grant before the edge, outputs after it
    task automatic step(input bit r, input logic [N-1:0] v, input logic [N-1:0] a,
                        input logic [N-1:0] b, input logic [3*N-1:0] op, input bit rr);
        logic [N-1:0] er;
        int w;
        rst        = r;
        req_valid  = v;
        req_a      = a;
        req_b      = b;
        req_op     = op;
        resp_ready = rr;
        #1;
        er = '0;
        w  = -1;
        if (!r && (!m_valid || rr)) begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (m_ptr + k) % N;
                if (w < 0 && v[idx]) w = idx;
            end
        end
        if (w >= 0) er[w] = 1'b1;
        obs_ready = req_ready;
        chk("req_ready", req_ready, er);
        @(posedge clk);
        #1;
        if (r) begin
            m_valid = 0; m_id = 0; m_y = 0; m_err = 0; m_ptr = 0;
        end else if (w >= 0) begin
            m_valid = 1;
            m_id    = w;
            m_y     = gate(a[w], b[w], int'(op[3*w +: 3]));
            m_err   = (op[3*w +: 3] >= 3'd6);
            m_ptr   = (w + 1) % N;
        end else if (m_valid && rr) begin
            m_valid = 0;
        end
        chk("resp_valid", resp_valid, m_valid);
        chk("resp_id", resp_id, m_id);
        chk("resp_y", resp_y, m_y);
`ifdef GATE_ARB_ERR_EN
        chk("resp_err", resp_err, m_err);
`endif
    endtask

    initial begin
        // Reset held two cycles with every requester asking
        step(1, 4'b1111, '0, '0, '0, 1);
        step(1, 4'b1111, '0, '0, '0, 1);
        chk("reset_valid", resp_valid, 0);
        chk("reset_id", resp_id, 0);

        // Single XOR request from requester 2
        step(0, 4'b0100, 4'b0100, 4'b0000, 12'(4) << 6, 1);
        chk("single_ready", obs_ready, 4'b0100);
        chk("single_id", resp_id, 2);
        chk("single_y", resp_y, 1);

        // Round robin with everyone requesting: 0,1,2,3,0
        step(1, 4'b0000, '0, '0, '0, 1);
        for (int i = 0; i < 5; i++) begin
            step(0, 4'b1111, 4'b1010, 4'b0110, 12'h5a3, 1);
            order_exp = '0;
            order_exp[i % N] = 1'b1;
            chk("rr_order", obs_ready, order_exp);
            chk("rr_id", resp_id, i % N);
        end

        // Backpressure: slot holds id=1,y=0 while resp_ready is low
        step(1, 4'b0000, '0, '0, '0, 1);
        step(0, 4'b0010, 4'b0000, 4'b0000, 12'h000, 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 4'b0001, 4'b0001, 4'b0001, 12'h001, 0);
            chk("bp_ready", obs_ready, 4'b0000);
            chk("bp_id", resp_id, 1);
            chk("bp_y", resp_y, 0);
        end
        step(0, 4'b0001, 4'b0001, 4'b0001, 12'h001, 1);
        chk("bp_release_ready", obs_ready, 4'b0001);
        chk("bp_release_id", resp_id, 0);
        chk("bp_release_y", resp_y, 1);

        // Truth table sweep through requester 3, including reserved op 7
        for (int op = 0; op < 8; op++) begin
            if (op == 6) continue;
            for (int ab = 0; ab < 4; ab++) begin
                step(0, 4'b1000, {ab[1], 3'b000}, {ab[0], 3'b000}, 12'(op) << 9, 1);
            end
        end
        step(0, 4'b1000, 4'b1000, 4'b1000, 12'(7) << 9, 1);
        chk("op7_y", resp_y, 0);
        step(0, 4'b1000, 4'b1000, 4'b0000, 12'(2) << 9, 1);
        chk("nand_10", resp_y, 1);

        // Reset mid-traffic with pointer at 3
        step(1, 4'b0000, '0, '0, '0, 1);
        step(0, 4'b0100, 4'b0100, 4'b0100, 12'(1) << 6, 1);
        step(1, 4'b1001, '0, '0, '0, 0);
        chk("midrst_valid", resp_valid, 0);
        step(0, 4'b1001, 4'b1001, 4'b0000, 12'h000, 1);
        chk("midrst_first", obs_ready, 4'b0001);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) == 0), 4'($urandom), 4'($urandom), 4'($urandom),
                 12'($urandom), ($urandom_range(0, 9) < 7));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
